// File: rtl/riscv_defs.sv
// Shared constants for the RISC-V core front end.
package riscv_defs;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/fetch_fifo.sv
// Small first-word-fall-through queue with push/pop/flush and an occupancy count.
// The head entry is readable combinationally. The head leaves when pop_i is asserted.
// A push into a full queue is legal only when the head leaves in the same cycle.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointer/count update. A flush overrides any push or pop in the same cycle.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array. It is not reset because its contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The credit scheme upstream must never push into a full queue without a pop.
  overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !flush_i && full && !do_pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// It holds the PC and issues in-order word fetches. Returned words are queued with
// their PCs and handed to decode over a valid/ready interface. A redirect from
// execute flushes the queue, and every response still owed by memory is discarded.
module fetch_unit
  import riscv_defs::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc,
  input  logic               id_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + INSTR_W;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   outstanding;  // occupancy of the PC tag queue = fetches awaiting a response
  logic [CW-1:0]   q_count;
  logic [XLEN-1:0] tag_pc;
  logic [EW-1:0]   head;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_fire;
  logic            pop;
  logic            push;

  // Handshakes and issue gating. A pop in the same cycle frees a slot, so a 1-cycle memory streams without gaps.
  always_comb begin
    id_valid       = (q_count != '0);
    pop            = id_valid && id_ready;
    credit_used    = (CW+1)'(outstanding) + (CW+1)'(q_count) - (CW+1)'(pop);
    imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid;
    push           = rsp_fire && (drop_q == '0) && !redirect_valid;
    id_pc          = id_valid ? head[EW-1:INSTR_W] : RESET_PC;
    id_instr       = id_valid ? head[INSTR_W-1:0]  : NOP_INSTR;
  end

  // Next PC and drop count.
  // On a redirect, every response still owed after this cycle must be dropped.
  // A response arriving in the redirect cycle is already discarded and is not counted.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      drop_d = outstanding - CW'(rsp_fire);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // PC and drop counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // PC tag queue.
  // Each accepted request pushes its address, and each response pops one, dropped or not.
  // It is never flushed, so it stays aligned with memory's response stream.
  fetch_fifo #(
    .W     (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_fire),
    .flush_i (1'b0),
    .data_o  (tag_pc),
    .count_o (outstanding)
  );

  // Instruction queue feeding decode. It is flushed by a redirect, which wins over push and pop.
  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({tag_pc, imem_rsp_data}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_o  (head),
    .count_o (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1- or 2-cycle in-order instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  int total = 0;
  int bad   = 0;

  // memory model state
  logic        lat2;
  logic        s1_v, s2_v;
  logic [31:0] s1_d, s2_d;

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (2),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction word stored at each address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return a + 32'h1300_0000;
  endfunction

  // In-order memory: response 1 or 2 cycles after accept. It shares the design's reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_d <= 32'h0;
      s2_d <= 32'h0;
    end else begin
      s1_v <= imem_req_valid && imem_req_ready;
      s1_d <= memword(imem_req_addr);
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end
  assign imem_rsp_valid = lat2 ? s2_v : s1_v;
  assign imem_rsp_data  = lat2 ? s2_d : s1_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic wait_id_valid(input int budget);
    int n = 0;
    while (!id_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Expect n consecutive deliveries base, base+4, ... (gaps allowed, no foreign entries).
  task automatic expect_stream(input string tag, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      wait_id_valid(20);
      check_eq($sformatf("%s_valid%0d", tag, k), 32'(id_valid), 32'd1);
      check_eq($sformatf("%s_pc%0d", tag, k), id_pc, base + 32'(4 * k));
      check_eq($sformatf("%s_instr%0d", tag, k), id_instr, memword(base + 32'(4 * k)));
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b1;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    lat2           = 1'b0;

    // Reset state
    #2;
    check_eq("rst_id_valid", 32'(id_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_id_pc", id_pc, 32'h0);
    check_eq("rst_id_instr", id_instr, 32'h0000_0013);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("first_req_addr", imem_req_addr, 32'h0);

    // Test 1: 1-cycle memory, full-rate stream with no gaps
    wait_id_valid(20);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t1_valid%0d", k), 32'(id_valid), 32'd1);
      check_eq($sformatf("t1_pc%0d", k), id_pc, 32'(4 * k));
      check_eq($sformatf("t1_instr%0d", k), id_instr, memword(32'(4 * k)));
      @(negedge clk);
    end

    // Test 2: decode stall. Head 0x10 must hold and requests must stop at the credit limit.
    id_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t2_valid%0d", k), 32'(id_valid), 32'd1);
      check_eq($sformatf("t2_pc%0d", k), id_pc, 32'h10);
      check_eq($sformatf("t2_instr%0d", k), id_instr, memword(32'h10));
      check_eq($sformatf("t2_noreq%0d", k), 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      #1;
    end

    // Test 6: reset while stalled with a full queue, then refetch from RESET_PC
    reset = 1'b1;
    #1;
    check_eq("t6_id_valid", 32'(id_valid), 32'd0);
    check_eq("t6_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("t6_id_pc", id_pc, 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    id_ready = 1'b1;
    #1;
    check_eq("t6_req_addr", imem_req_addr, 32'h0);
    expect_stream("t6", 32'h0, 2);

    // Test 3: drain memory, switch to 2-cycle latency, and redirect with two fetches in flight
    imem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    lat2           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    n = 0;
    while (!(s1_v && s2_v) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_two_in_flight", 32'(s1_v && s2_v), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check_eq("t3_noreq", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_stream("t3", 32'h100, 2);

    // Test 4: misaligned redirect target is forced to a word address
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    check_eq("t4_noreq", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t4_req_addr", imem_req_addr, 32'h200);
    @(negedge clk);
    expect_stream("t4", 32'h200, 2);

    // Test 5: redirect with a response and a pop in the same cycle, then a back-to-back redirect
    n = 0;
    while (!(id_valid && imem_rsp_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_rsp_and_pop", 32'(id_valid && imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    check_eq("t5_noreq", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    check_eq("t5_flush", 32'(id_valid), 32'd0);
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_eq("t5_flush2", 32'(id_valid), 32'd0);
    expect_stream("t5", 32'h400, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
